data_memory_lat: RTL and testbench

Parametrised word-addressed data memory for the MEM stage of the pipelined MIPS processor, modelling a slow main memory with a configurable read latency. It adds byte-enable writes, a one-entry last-read hit buffer for zero-stall repeat reads, a `read_valid` strobe and misalignment reporting. The processor holds `read`, `write`, `address`, `write_data` and `byte_en` stable while `stall` is high.

---
 rtl/data_memory_lat.sv | 169 ++++++++++++++++
 tb/tb_data_memory_lat.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_lat.sv
// data_memory_lat
// Word-addressed data memory for the MEM stage with a slow, configurable read
// latency, byte-enable writes, a one-entry last-read hit buffer, a read_valid
// strobe and a registered misalignment pulse.
//
// Parameters
//   ADDR_W   : word-index bits (depth = 2**ADDR_W 32-bit words)
//   READ_LAT : cycles stall stays high on a read miss (>= 1)
//   HIT_EN   : 1 enables the last-read hit buffer, 0 makes every read a miss
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   read, write            : level requests, held stable while stall is high
//   address                : byte address, word index is address[ADDR_W+1:2]
//   write_data, byte_en    : store data and per-byte lane enables
//   read_data              : load data, valid when read_valid is high
//   stall                  : combinational, high while a read is outstanding
//   read_valid             : combinational, high in the cycle data is presented
//   misaligned             : one-cycle pulse after an accepted access with
//                            address[1:0] != 0
//
// Handshake: a read is accepted in IDLE. On a hit, data and read_valid appear
// in the same cycle with no stall. On a miss, stall is high for READ_LAT
// cycles and read_valid/read_data follow in the next cycle (DONE). Writes are
// accepted only in IDLE, commit at that edge and never stall.
module data_memory_lat #(
    parameter int ADDR_W   = 16,
    parameter int READ_LAT = 20,
    parameter int HIT_EN   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_en,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        read_valid,
    output logic        misaligned
);

    localparam int CNT_W = $clog2(READ_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] tag;
    logic              tag_valid;
    logic [31:0]       rdata_q;

    logic [31:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] word;
    logic [31:0]       ram_word;
    logic [31:0]       merged;
    logic              hit;
    logic              accept_wr;
    logic              miss_start;
    logic              capture;
    logic [31:0]       capture_data;
    logic              stall_c;
    logic              read_valid_c;
    logic              unused_addr;

    // Upper address bits are ignored so the address space wraps.
    assign word        = address[ADDR_W+1:2];
    assign unused_addr = ^address[31:ADDR_W+2];
    assign ram_word    = mem[word];

    // A pending write is never a hit: it forces a miss so the capture
    // returns the post-write word.
    assign hit       = (HIT_EN != 0) && tag_valid && (tag == word) && !write;
    assign accept_wr = (state == IDLE) && write;

    always_comb begin
        merged = ram_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                merged[8*i +: 8] = write_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_next   = state;
        stall_c      = 1'b0;
        read_valid_c = 1'b0;
        miss_start   = 1'b0;
        case (state)
            IDLE: begin
                if (read) begin
                    if (hit) begin
                        read_valid_c = 1'b1;
                    end else begin
                        stall_c    = 1'b1;
                        miss_start = 1'b1;
                        state_next = (READ_LAT == 1) ? DONE : WAIT;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Always return to IDLE so a still-high read does not restart
                // in this cycle; it is re-evaluated as a fresh read in IDLE.
                read_valid_c = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // With a one-cycle latency the capture happens at the accepting edge, so
    // a simultaneous write must be merged into the captured word directly.
    assign capture      = (miss_start && (READ_LAT == 1)) ||
                          ((state == WAIT) && (cnt == CNT_LAST));
    assign capture_data = accept_wr ? merged : ram_word;

    assign stall      = rst_n && stall_c;
    assign read_valid = rst_n && read_valid_c;
    assign read_data  = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            tag        <= '0;
            tag_valid  <= 1'b0;
            rdata_q    <= '0;
            misaligned <= 1'b0;
        end else begin
            state <= state_next;
            if (miss_start) begin
                cnt <= CNT_ONE;
            end else if (state == WAIT) begin
                cnt <= cnt + CNT_ONE;
            end
            if (capture) begin
                rdata_q   <= capture_data;
                tag       <= word;
                tag_valid <= 1'b1;
            end else if (accept_wr && (word == tag)) begin
                tag_valid <= 1'b0;
            end
            misaligned <= (state == IDLE) && (read || write) && (address[1:0] != 2'b00);
        end
    end

    // RAM contents are not reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && accept_wr) begin
            mem[word] <= merged;
        end
    end

endmodule

// File: tb/tb_data_memory_lat.sv
// tb_data_memory_lat
// Bench for data_memory_lat. A transaction-level model (word array, last-read
// buffer, expected latency) produces one expected output vector per cycle into
// exp_q; a single negedge process compares the DUT against it. A second
// instance with READ_LAT=1, HIT_EN=0, ADDR_W=4 covers the small configuration.
module tb_data_memory_lat;

    localparam int LAT = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        read, write;
    logic [31:0] address, write_data, read_data;
    logic [3:0]  byte_en;
    logic        stall, read_valid, misaligned;

    logic        read2, write2;
    logic [31:0] address2, write_data2, read_data2;
    logic [3:0]  byte_en2;
    logic        stall2, read_valid2, misaligned2;

    data_memory_lat dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read       (read),
        .write      (write),
        .address    (address),
        .write_data (write_data),
        .byte_en    (byte_en),
        .read_data  (read_data),
        .stall      (stall),
        .read_valid (read_valid),
        .misaligned (misaligned)
    );

    data_memory_lat #(.ADDR_W(4), .READ_LAT(1), .HIT_EN(0)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .read       (read2),
        .write      (write2),
        .address    (address2),
        .write_data (write_data2),
        .byte_en    (byte_en2),
        .read_data  (read_data2),
        .stall      (stall2),
        .read_valid (read_valid2),
        .misaligned (misaligned2)
    );

    int checks = 0;
    int errors = 0;

    // {stall, read_valid, misaligned, read_data}
    logic [34:0] exp_q[$];

    // Reference model state
    logic [31:0] mm [logic [15:0]];
    logic        hb_valid = 1'b0;
    logic [15:0] hb_word  = '0;
    logic [31:0] last_data = '0;
    logic        mis_next = 1'b0;

    int          run_len = 0;
    int          seen_stall = -1;
    logic [31:0] seen_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // Compare process
    always @(negedge clk) begin
        logic [34:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall",      {31'd0, stall},      {31'd0, e[34]});
            chk("read_valid", {31'd0, read_valid}, {31'd0, e[33]});
            chk("misaligned", {31'd0, misaligned}, {31'd0, e[32]});
            chk("read_data",  read_data,           e[31:0]);
        end
        if (read_valid) begin
            seen_stall = run_len;
            seen_data  = read_data;
        end
        run_len = stall ? run_len + 1 : 0;
    end

    // One clock cycle of stimulus plus its expected outputs.
    task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic rn, input logic st, input logic rv,
                       input logic acc_mis);
        read       = r;
        write      = w;
        address    = a;
        write_data = wd;
        byte_en    = be;
        rst_n      = rn;
        exp_q.push_back({st, rv, mis_next, last_data});
        mis_next = acc_mis;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input logic r);
        last_data = '0;
        hb_valid  = 1'b0;
        mis_next  = 1'b0;
        repeat (n) cyc(r, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [15:0] wi;
        logic [31:0] old_w;
        wi = a[17:2];
        cyc(1'b0, 1'b1, a, wd, be, 1'b1, 1'b0, 1'b0, a[1:0] != 2'b00);
        old_w = mm.exists(wi) ? mm[wi] : 32'h0;
        mm[wi] = merge(old_w, wd, be);
        if (hb_valid && hb_word == wi) hb_valid = 1'b0;
    endtask

    // abort_at >= 0 resets the design at that stall cycle of a miss.
    task automatic do_read(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                           input logic [3:0] be, input int abort_at);
        logic [15:0] wi;
        logic        mis;
        logic [31:0] old_w;
        wi  = a[17:2];
        mis = a[1:0] != 2'b00;
        if (hb_valid && hb_word == wi && !wr) begin
            cyc(1'b1, 1'b0, a, wd, be, 1'b1, 1'b0, 1'b1, mis);
            return;
        end
        if (wr) begin
            old_w = mm.exists(wi) ? mm[wi] : 32'h0;
            mm[wi] = merge(old_w, wd, be);
            if (hb_valid && hb_word == wi) hb_valid = 1'b0;
        end
        for (int i = 0; i < LAT; i++) begin
            if (i == abort_at) begin
                do_reset(2, 1'b1);
                return;
            end
            cyc(1'b1, wr, a, wd, be, 1'b1, 1'b1, 1'b0, (i == 0) ? mis : 1'b0);
        end
        last_data = mm[wi];
        hb_valid  = 1'b1;
        hb_word   = wi;
        cyc(1'b1, wr, a, wd, be, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] a, last_a, hi;
        int          op, w, off;

        rst_n = 1'b1;
        read = 1'b0; write = 1'b0; address = '0; write_data = '0; byte_en = '0;
        read2 = 1'b0; write2 = 1'b0; address2 = '0; write_data2 = '0; byte_en2 = '0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2, 1'b0);

        // Directed sequence
        do_write(32'h100, 32'hDEADBEEF, 4'hF);
        seen_stall = -1;
        do_read(32'h100, 1'b0, 32'h0, 4'h0, -1);
        chk("miss_lat", 32'(seen_stall), 32'd20);
        chk("miss_data", seen_data, 32'hDEADBEEF);

        seen_stall = -1;
        do_read(32'h100, 1'b0, 32'h0, 4'h0, -1);
        chk("hit_lat", 32'(seen_stall), 32'd0);
        chk("hit_data", seen_data, 32'hDEADBEEF);

        do_write(32'h100, 32'h000000AA, 4'b0001);
        seen_stall = -1;
        do_read(32'h100, 1'b0, 32'h0, 4'h0, -1);
        chk("inval_lat", 32'(seen_stall), 32'd20);
        chk("inval_data", seen_data, 32'hDEADBEAA);

        seen_stall = -1;
        do_read(32'h200, 1'b1, 32'h12345678, 4'hF, -1);
        chk("rw_lat", 32'(seen_stall), 32'd20);
        chk("rw_data", seen_data, 32'h12345678);

        do_read(32'h102, 1'b0, 32'h0, 4'h0, -1);
        chk("misal_data", seen_data, 32'hDEADBEAA);

        do_read(32'h200, 1'b0, 32'h0, 4'h0, 10);
        seen_stall = -1;
        do_read(32'h100, 1'b0, 32'h0, 4'h0, -1);
        chk("post_abort_lat", 32'(seen_stall), 32'd20);
        chk("post_abort_data", seen_data, 32'hDEADBEAA);

        // Randomized phase over a small pool of initialised words
        for (int i = 0; i < 8; i++) do_write(32'h2000 + 32'(i * 4), $urandom(), 4'hF);
        last_a = 32'h2000;
        for (int n = 0; n < 40; n++) begin
            op  = $urandom_range(0, 4);
            w   = $urandom_range(0, 7);
            off = $urandom_range(0, 3);
            hi  = $urandom() & 32'hFFFC0000;
            a   = hi | (32'h2000 + 32'(w * 4)) | 32'(off);
            case (op)
                0: do_write(a, $urandom(), 4'($urandom_range(1, 15)));
                1: begin do_read(a, 1'b0, 32'h0, 4'h0, -1); last_a = a; end
                2: do_read(last_a, 1'b0, 32'h0, 4'h0, -1);
                3: begin do_read(a, 1'b1, $urandom(), 4'($urandom_range(1, 15)), -1); last_a = a; end
                default: idle_cyc();
            endcase
        end
        idle_cyc();

        // Small configuration: READ_LAT=1, HIT_EN=0, ADDR_W=4
        write2 = 1'b1; address2 = 32'h40; write_data2 = 32'h55; byte_en2 = 4'hF;
        @(posedge clk); #1;
        write2 = 1'b0; read2 = 1'b1; address2 = 32'h0;
        @(negedge clk);
        chk("p_miss_stall", {31'd0, stall2}, 32'd1);
        chk("p_miss_rv", {31'd0, read_valid2}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("p_done_stall", {31'd0, stall2}, 32'd0);
        chk("p_done_rv", {31'd0, read_valid2}, 32'd1);
        chk("p_done_data", read_data2, 32'h55);
        @(posedge clk); #1;
        @(negedge clk);
        chk("p_rep_stall", {31'd0, stall2}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("p_rep_rv", {31'd0, read_valid2}, 32'd1);
        chk("p_rep_data", read_data2, 32'h55);
        @(posedge clk); #1;
        read2 = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
